ibuf: RTL and testbench
=======================

IBUF -- requirements
Module: ibuf

Interface
REQ-001 Parameter SYNC_STAGES, default 3: number of synchronizer flops, legal range 2..8.
REQ-002 Parameter DEBOUNCE_COUNT, default 15: number of consecutive differing samples required before the clean output changes, legal range 1..65535.
REQ-003 Parameter CNT_WIDTH, default 16: width of the debounce counter, SHALL hold DEBOUNCE_COUNT.
REQ-004 clock  input  1  single system clock, all state rising-edge triggered.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 I  input  1  raw asynchronous pad input, e.g. a push-button.
REQ-007 O  output  1  combinational buffered copy of I.
REQ-008 O_sync  output  1  I after the SYNC_STAGES-flop synchronizer.
REQ-009 O_clean  output  1  debounced, synchronized level.
REQ-010 rise  output  1  one-cycle pulse on an O_clean 0->1 transition.
REQ-011 fall  output  1  one-cycle pulse on an O_clean 1->0 transition.
REQ-012 count  output  8  number of rise events, modulo 256.

Function
REQ-013 O SHALL equal I at all times, with no register and no dependence on clock or reset.
REQ-014 The synchronizer SHALL be a shift chain: the stage-0 flop samples I and O_sync is the last stage, so O_sync follows I with exactly SYNC_STAGES clock edges of latency.
REQ-015 The debounce counter SHALL be cleared on every edge where O_sync equals O_clean.
REQ-016 While O_sync differs from O_clean and the counter is below DEBOUNCE_COUNT, the counter SHALL increment by 1 per edge.
REQ-017 When the counter equals DEBOUNCE_COUNT and O_sync still differs from O_clean, O_clean SHALL load O_sync and the counter SHALL clear on the same edge.
REQ-018 O_clean SHALL change exactly DEBOUNCE_COUNT+1 edges after O_sync changes, provided O_sync is held stable over that interval.
REQ-019 Any return of O_sync to the O_clean value before the load edge SHALL clear the counter, and O_clean SHALL NOT change.
REQ-020 The counter SHALL never exceed DEBOUNCE_COUNT and SHALL never wrap.
REQ-021 A register O_clean_d SHALL hold O_clean delayed by one edge.
REQ-022 rise SHALL be O_clean AND NOT O_clean_d, giving exactly one cycle high per 0->1 transition.
REQ-023 fall SHALL be NOT O_clean AND O_clean_d, giving exactly one cycle high per 1->0 transition.
REQ-024 rise and fall SHALL never be high in the same cycle.
REQ-025 count SHALL increment by 1 on the edge at which O_clean loads 1 from 0, so the new value is visible in the same cycle rise is high.
REQ-026 count SHALL wrap from 255 to 0 with no flag.
REQ-027 fall events SHALL NOT affect count.

Reset
REQ-028 On any edge with reset=1 the following SHALL be cleared: all synchronizer flops, the debounce counter, O_clean, O_clean_d and count.
REQ-029 During and after reset, rise and fall SHALL be 0 until a new debounced transition occurs.
REQ-030 Reset SHALL take priority over all other updates, including a reset asserted mid-debounce.
REQ-031 O SHALL be unaffected by reset.
REQ-032 After reset deassertion with I=1, O_clean SHALL rise through the normal debounce path and produce one rise pulse and count=1.

Verification (defaults SYNC_STAGES=3, DEBOUNCE_COUNT=15)
REQ-033 Reset, then drive I 0->1 and hold -> O=1 immediately; O_sync=1 after 3 edges; O_clean=1 and rise=1 for one cycle 19 edges after the I change; count=1.
REQ-034 From O_clean=1, drive I 1->0 and hold -> fall pulses once after 19 edges; count stays 1.
REQ-035 Drive a 5-cycle high glitch on I, then return I low -> O_sync pulses; O_clean, rise and count stay 0.
REQ-036 Make 256 clean presses, each held for 40 cycles and released for 40 cycles -> count steps 1..255, then reads 0 after press 256.
REQ-037 Assert reset for 1 cycle while the counter is at 10 with I held high -> all state is 0 on the next cycle; O_clean rises 19 edges after reset release.
REQ-038 Toggle I every cycle for 100 cycles -> O_clean never changes; no rise or fall pulses occur.

Source files
------------

// File: rtl/ibuf.sv
// ibuf: pad input buffer with a multi-flop synchronizer, a counter
// debouncer, one-cycle edge pulses and a rise-event counter.
module ibuf #(
    parameter int SYNC_STAGES    = 3,
    parameter int DEBOUNCE_COUNT = 15,
    parameter int CNT_WIDTH      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       I,
    output logic       O,
    output logic       O_sync,
    output logic       O_clean,
    output logic       rise,
    output logic       fall,
    output logic [7:0] count
);
    localparam logic [CNT_WIDTH-1:0] DB_MAX = CNT_WIDTH'(DEBOUNCE_COUNT);
    localparam logic [CNT_WIDTH-1:0] DB_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_WIDTH-1:0]   db_cnt;
    logic                   O_clean_d;

    assign O      = I;
    assign O_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], I};
        end
    end

    // Counter only runs while the synchronized level disagrees with O_clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt    <= '0;
            O_clean   <= 1'b0;
            O_clean_d <= 1'b0;
            count     <= 8'd0;
        end else begin
            O_clean_d <= O_clean;
            if (O_sync == O_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_cnt  <= '0;
                O_clean <= O_sync;
                if (O_sync) begin
                    count <= count + 8'd1;
                end
            end else begin
                db_cnt <= db_cnt + DB_ONE;
            end
        end
    end

    assign rise = O_clean & ~O_clean_d;
    assign fall = ~O_clean & O_clean_d;

endmodule

// File: tb/tb_ibuf.sv
// tb_ibuf: randomized and directed checks of ibuf against a
// run-length behavioural model of synchronizer plus debouncer.
module tb_ibuf;
    localparam int SS = 3;
    localparam int DB = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       I     = 1'b0;
    logic       O;
    logic       O_sync;
    logic       O_clean;
    logic       rise;
    logic       fall;
    logic [7:0] count;

    int n_pass  = 0;
    int n_total = 0;

    ibuf #(
        .SYNC_STAGES(SS),
        .DEBOUNCE_COUNT(DB),
        .CNT_WIDTH(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .I(I),
        .O(O),
        .O_sync(O_sync),
        .O_clean(O_clean),
        .rise(rise),
        .fall(fall),
        .count(count)
    );

    always #5 clock = ~clock;

    // Model: O_sync is the I sample taken SS-1 edges earlier; O_clean
    // flips once O_sync has disagreed with it for DB+1 straight edges.
    logic       hist[$];
    logic       m_sync  = 1'b0;
    logic       m_clean = 1'b0;
    logic       m_rise  = 1'b0;
    logic       m_fall  = 1'b0;
    logic [7:0] m_count = 8'd0;
    int         m_run   = 0;

    always @(posedge clock) begin
        if (reset) begin
            hist.delete();
            m_sync  = 1'b0;
            m_clean = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_count = 8'd0;
            m_run   = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_sync != m_clean) begin
                m_run = m_run + 1;
                if (m_run == DB + 1) begin
                    m_clean = m_sync;
                    m_run   = 0;
                    if (m_clean) begin
                        m_rise  = 1'b1;
                        m_count = m_count + 8'd1;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            hist.push_back(I);
            if (hist.size() > SS) void'(hist.pop_front());
            m_sync = (hist.size() == SS) ? hist[0] : 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            I = 1'($urandom_range(0, 1));
            step();
            n_total++;
            if ({O, O_sync, O_clean, rise, fall, count} !== {I, 12'd0})
                $display("FAIL reset_state: got %b expected %b",
                         {O, O_sync, O_clean, rise, fall, count}, {I, 12'd0});
            else n_pass++;
        end
        I = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_press();
        logic [12:0] exp;
        I = 1'b1;
        #1;
        n_total++;
        if (O !== 1'b1) $display("FAIL press_O_immediate: got %b expected 1", O);
        else n_pass++;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp = {1'b1, 1'(k >= SS), 1'(k >= SS + DB + 1),
                   1'(k == SS + DB + 1), 1'b0,
                   (k >= SS + DB + 1) ? 8'd1 : 8'd0};
            n_total++;
            if ({O, O_sync, O_clean, rise, fall, count} !== exp)
                $display("FAIL press edge %0d: got %b expected %b", k,
                         {O, O_sync, O_clean, rise, fall, count}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_release();
        logic [12:0] exp;
        I = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp = {1'b0, 1'(k < SS), 1'(k < SS + DB + 1), 1'b0,
                   1'(k == SS + DB + 1), 8'd1};
            n_total++;
            if ({O, O_sync, O_clean, rise, fall, count} !== exp)
                $display("FAIL release edge %0d: got %b expected %b", k,
                         {O, O_sync, O_clean, rise, fall, count}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        bit saw_sync;
        reset = 1'b1;
        I = 1'b0;
        step();
        reset = 1'b0;
        saw_sync = 0;
        for (int k = 0; k < 40; k++) begin
            I = (k < 5);
            step();
            if (O_sync) saw_sync = 1;
            n_total++;
            if ({O_clean, rise, fall, count} !== 11'd0)
                $display("FAIL glitch cycle %0d: got %b expected 0", k,
                         {O_clean, rise, fall, count});
            else n_pass++;
        end
        n_total++;
        if (!saw_sync) $display("FAIL glitch_sync_pulse: got 0 expected 1");
        else n_pass++;
    endtask

    task automatic test_count_wrap();
        logic [7:0] want;
        reset = 1'b1;
        I = 1'b0;
        step();
        reset = 1'b0;
        for (int p = 1; p <= 256; p++) begin
            for (int k = 0; k < 80; k++) begin
                I = (k < 40);
                step();
                n_total++;
                if ({O, O_sync, O_clean, rise, fall, count} !==
                    {I, m_sync, m_clean, m_rise, m_fall, m_count})
                    $display("FAIL wrap_model p%0d c%0d: got %b expected %b",
                             p, k, {O, O_sync, O_clean, rise, fall, count},
                             {I, m_sync, m_clean, m_rise, m_fall, m_count});
                else n_pass++;
                if (k == 39) begin
                    want = 8'(p);
                    n_total++;
                    if (count !== want)
                        $display("FAIL wrap_count press %0d: got %0d expected %0d",
                                 p, count, want);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        I = 1'b0;
        step();
        reset = 1'b0;
        I = 1'b1;
        for (int k = 0; k < SS + 10; k++) step();
        reset = 1'b1;
        step();
        n_total++;
        if ({O_sync, O_clean, rise, fall, count} !== 12'd0)
            $display("FAIL reset_mid_state: got %b expected 0",
                     {O_sync, O_clean, rise, fall, count});
        else n_pass++;
        reset = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            step();
            n_total++;
            if ({O_clean, rise} !== {1'(k >= SS + DB + 1), 1'(k == SS + DB + 1)})
                $display("FAIL reset_mid edge %0d: got %b expected %b", k,
                         {O_clean, rise},
                         {1'(k >= SS + DB + 1), 1'(k == SS + DB + 1)});
            else n_pass++;
        end
        n_total++;
        if (count !== 8'd1)
            $display("FAIL reset_mid_count: got %0d expected 1", count);
        else n_pass++;
    endtask

    task automatic test_toggle();
        logic start;
        start = m_clean;
        for (int k = 0; k < 100; k++) begin
            I = ~I;
            step();
            n_total++;
            if ({O_clean, rise, fall} !== {start, 2'b00})
                $display("FAIL toggle cycle %0d: got %b expected %b", k,
                         {O_clean, rise, fall}, {start, 2'b00});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold;
        for (int k = 0; k < 4000; k++) begin
            if (hold <= 0) begin
                I = ~I;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8)
                                                   : $urandom_range(10, 40);
            end
            hold--;
            reset = ($urandom_range(0, 299) == 0);
            step();
            n_total++;
            if ({O, O_sync, O_clean, rise, fall, count} !==
                {I, m_sync, m_clean, m_rise, m_fall, m_count})
                $display("FAIL random cycle %0d: got %b expected %b", k,
                         {O, O_sync, O_clean, rise, fall, count},
                         {I, m_sync, m_clean, m_rise, m_fall, m_count});
            else n_pass++;
            n_total++;
            if ((rise & fall) !== 1'b0)
                $display("FAIL random_rise_fall cycle %0d: got 1 expected 0", k);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_count_wrap();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
